// File: rtl/regfile_pkg.sv
// Shared widths and types for the register-file writeback scoreboard.
package regfile_pkg;

    localparam int unsigned N    = 32;
    localparam int unsigned NREG = 32;
    localparam int unsigned AW   = $clog2(NREG);

    typedef logic [AW-1:0] reg_addr_t;

    typedef struct packed {
        reg_addr_t      rd;
        logic [N-1:0]   data;
    } wb_req_t;

    typedef enum logic {GNT_ALU, GNT_LSU} grant_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter; req/gnt bit 0 is ALU, bit 1 is LSU.
module rr_arb2
    import regfile_pkg::*;
(
    input  logic       clock,
    input  logic       nreset,
    input  logic [1:0] i_req,
    output logic [1:0] o_gnt
);

    grant_e r_last;

    // On a tie, favour whichever requester did not win last time.
    always_comb begin
        o_gnt = 2'b00;
        if (i_req == 2'b11) begin
            o_gnt = (r_last == GNT_ALU) ? 2'b10 : 2'b01;
        end else begin
            o_gnt = i_req;
        end
    end

    always_ff @(posedge clock) begin
        if (!nreset) begin
            r_last <= GNT_ALU;
        end else if (o_gnt[1]) begin
            r_last <= GNT_LSU;
        end else if (o_gnt[0]) begin
            r_last <= GNT_ALU;
        end
    end

endmodule

// File: rtl/regfile_wb_scoreboard.sv
// Register-file write-port sequencer with per-register busy scoreboard.
// Define WB_BYPASS_EN to add writeback forwarding outputs fwd1/fwd2/fwd_data.
module regfile_wb_scoreboard
    import regfile_pkg::*;
(
    input  logic            clock,
    input  logic            nreset,
    input  logic            iss_valid,
    input  logic [AW-1:0]   iss_rd,
    output logic            iss_ready,
    input  logic [AW-1:0]   rs1,
    input  logic [AW-1:0]   rs2,
    output logic            rs_stall,
    input  logic            alu_valid,
    input  logic [AW-1:0]   alu_rd,
    input  logic [N-1:0]    alu_data,
    output logic            alu_ready,
    input  logic            lsu_valid,
    input  logic [AW-1:0]   lsu_rd,
    input  logic [N-1:0]    lsu_data,
    output logic            lsu_ready,
    output logic            regw,
    output logic [AW-1:0]   regaddrW,
    output logic [N-1:0]    wdata,
`ifdef WB_BYPASS_EN
    output logic            fwd1,
    output logic            fwd2,
    output logic [N-1:0]    fwd_data,
`endif
    output logic [NREG-1:0] busy
);

    logic [NREG-1:0] r_busy;
    logic            r_regw;
    reg_addr_t       r_regaddrW;
    logic [N-1:0]    r_wdata;

    logic [1:0]      w_req;
    logic [1:0]      w_gnt;
    wb_req_t         w_sel;
    logic            w_clr_hit;
    logic            w_iss_fire;
    logic            w_fwd1;
    logic            w_fwd2;
    logic [NREG-1:0] w_busy_d;

    assign w_req = {lsu_valid, alu_valid} & {2{nreset}};

    rr_arb2 u_arb (
        .clock  (clock),
        .nreset (nreset),
        .i_req  (w_req),
        .o_gnt  (w_gnt)
    );

    assign alu_ready = w_gnt[0];
    assign lsu_ready = w_gnt[1];

    always_comb begin
        w_sel.rd   = alu_rd;
        w_sel.data = alu_data;
        if (w_gnt[1]) begin
            w_sel.rd   = lsu_rd;
            w_sel.data = lsu_data;
        end
    end

    // A destination whose write retires on this edge may be re-issued; set wins below.
    assign w_clr_hit  = r_regw && (r_regaddrW == iss_rd);
    assign iss_ready  = nreset && ((iss_rd == '0) || !r_busy[iss_rd] || w_clr_hit);
    assign w_iss_fire = iss_valid && iss_ready && (iss_rd != '0);

`ifdef WB_BYPASS_EN
    assign w_fwd1   = r_regw && (r_regaddrW != '0) && (r_regaddrW == rs1);
    assign w_fwd2   = r_regw && (r_regaddrW != '0) && (r_regaddrW == rs2);
    assign fwd1     = w_fwd1;
    assign fwd2     = w_fwd2;
    assign fwd_data = r_wdata;
`else
    assign w_fwd1 = 1'b0;
    assign w_fwd2 = 1'b0;
`endif

    assign rs_stall = (r_busy[rs1] && !w_fwd1) || (r_busy[rs2] && !w_fwd2);

    always_comb begin
        w_busy_d = r_busy;
        if (r_regw) begin
            w_busy_d[r_regaddrW] = 1'b0;
        end
        if (w_iss_fire) begin
            w_busy_d[iss_rd] = 1'b1;
        end
        w_busy_d[0] = 1'b0;
    end

    always_ff @(posedge clock) begin
        if (!nreset) begin
            r_busy     <= '0;
            r_regw     <= 1'b0;
            r_regaddrW <= '0;
            r_wdata    <= '0;
        end else begin
            r_busy <= w_busy_d;
            // Writes to x0 are consumed by the handshake but never reach the file.
            r_regw <= (|w_gnt) && (w_sel.rd != '0);
            if (|w_gnt) begin
                r_regaddrW <= w_sel.rd;
                r_wdata    <= w_sel.data;
            end
        end
    end

    assign busy     = r_busy;
    assign regw     = r_regw;
    assign regaddrW = r_regaddrW;
    assign wdata    = r_wdata;

endmodule

// File: tb/tb_regfile_wb_scoreboard.sv
// Scoreboard bench: stimulus pushes expected register writes, a monitor pops them on regw.
module tb_regfile_wb_scoreboard;
    import regfile_pkg::*;

    logic            clock = 1'b0;
    logic            nreset;
    logic            iss_valid;
    logic [AW-1:0]   iss_rd;
    logic            iss_ready;
    logic [AW-1:0]   rs1;
    logic [AW-1:0]   rs2;
    logic            rs_stall;
    logic            alu_valid;
    logic [AW-1:0]   alu_rd;
    logic [N-1:0]    alu_data;
    logic            alu_ready;
    logic            lsu_valid;
    logic [AW-1:0]   lsu_rd;
    logic [N-1:0]    lsu_data;
    logic            lsu_ready;
    logic            regw;
    logic [AW-1:0]   regaddrW;
    logic [N-1:0]    wdata;
    logic [NREG-1:0] busy;
`ifdef WB_BYPASS_EN
    logic            fwd1;
    logic            fwd2;
    logic [N-1:0]    fwd_data;
`endif

    int tests  = 0;
    int errors = 0;
    wb_req_t exp_q[$];

    always #5 clock = ~clock;

    regfile_wb_scoreboard dut (
        .clock     (clock),
        .nreset    (nreset),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .iss_ready (iss_ready),
        .rs1       (rs1),
        .rs2       (rs2),
        .rs_stall  (rs_stall),
        .alu_valid (alu_valid),
        .alu_rd    (alu_rd),
        .alu_data  (alu_data),
        .alu_ready (alu_ready),
        .lsu_valid (lsu_valid),
        .lsu_rd    (lsu_rd),
        .lsu_data  (lsu_data),
        .lsu_ready (lsu_ready),
        .regw      (regw),
        .regaddrW  (regaddrW),
        .wdata     (wdata),
`ifdef WB_BYPASS_EN
        .fwd1      (fwd1),
        .fwd2      (fwd2),
        .fwd_data  (fwd_data),
`endif
        .busy      (busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic push(input logic [AW-1:0] rd, input logic [N-1:0] data);
        wb_req_t e;
        e.rd   = rd;
        e.data = data;
        exp_q.push_back(e);
    endtask

    // Monitor: every write presented to the register file must match the oldest expectation.
    initial begin
        wb_req_t e;
        forever begin
            @(negedge clock);
            if (regw === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_write_addr", {27'd0, regaddrW}, 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    chk("wb_addr", {27'd0, regaddrW}, {27'd0, e.rd});
                    chk("wb_data", wdata, e.data);
                end
            end
        end
    end

    initial begin
        logic [AW-1:0] rd_tab [3];
        logic [N-1:0]  dat_tab[3];
        logic [1:0]    gnt_tab[3];
        rd_tab  = '{5'd4, 5'd3, 5'd4};
        dat_tab = '{32'h4444_0001, 32'h3333_0001, 32'h4444_0002};
        gnt_tab = '{2'b10, 2'b01, 2'b10};

        nreset = 1'b0; iss_valid = 1'b0; iss_rd = '0; rs1 = '0; rs2 = '0;
        alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'hA1A1_A1A1;
        lsu_valid = 1'b1; lsu_rd = 5'd2; lsu_data = 32'hB2B2_B2B2;

        // Reset with all requesters active
        for (int i = 0; i < 2; i++) begin
            step();
            chk("rst_regw", {31'd0, regw}, 32'd0);
            chk("rst_busy", busy, 32'd0);
            chk("rst_alu_ready", {31'd0, alu_ready}, 32'd0);
            chk("rst_lsu_ready", {31'd0, lsu_ready}, 32'd0);
            chk("rst_iss_ready", {31'd0, iss_ready}, 32'd0);
        end
        nreset = 1'b1;
        #1;
        chk("first_tie_lsu", {30'd0, lsu_ready, alu_ready}, 32'b10);
        push(5'd2, 32'hB2B2_B2B2);
        step();
        lsu_valid = 1'b0;
        #1;
        chk("lone_alu", {30'd0, lsu_ready, alu_ready}, 32'b01);
        push(5'd1, 32'hA1A1_A1A1);
        step();
        alu_valid = 1'b0;
        step();
        chk("spurious_wb_busy", busy, 32'd0);

        // Issue rd=5, ALU writeback rd=5
        iss_valid = 1'b1; iss_rd = 5'd5;
        #1;
        chk("iss5_ready", {31'd0, iss_ready}, 32'd1);
        step();
        iss_valid = 1'b0; rs1 = 5'd5;
        #1;
        chk("busy5_set", busy, 32'h0000_0020);
        chk("raw_stall5", {31'd0, rs_stall}, 32'd1);
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEAD_BEEF;
        #1;
        chk("alu5_ready", {31'd0, alu_ready}, 32'd1);
        push(5'd5, 32'hDEAD_BEEF);
        step();
        alu_valid = 1'b0;
        #1;
        chk("busy5_held_during_write", busy, 32'h0000_0020);
`ifdef WB_BYPASS_EN
        chk("bypass_rs1_stall", {31'd0, rs_stall}, 32'd0);
        chk("bypass_fwd1", {31'd0, fwd1}, 32'd1);
        chk("bypass_fwd_data", fwd_data, 32'hDEAD_BEEF);
`else
        chk("nobypass_rs1_stall", {31'd0, rs_stall}, 32'd1);
`endif
        step();
        chk("busy5_cleared", busy, 32'd0);
        chk("stall5_cleared", {31'd0, rs_stall}, 32'd0);
        rs1 = '0;

        // Contention: grants LSU, ALU, LSU
        alu_valid = 1'b1; lsu_valid = 1'b1; alu_rd = 5'd3; lsu_rd = 5'd4;
        alu_data = 32'h3333_0001; lsu_data = 32'h4444_0001;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("rr_grant", {30'd0, lsu_ready, alu_ready}, {30'd0, gnt_tab[i]});
            push(rd_tab[i], dat_tab[i]);
            step();
            if (i == 0) lsu_data = 32'h4444_0002;
            if (i == 1) alu_data = 32'h3333_0002;
        end
        alu_valid = 1'b0; lsu_valid = 1'b0;

        // x0: always ready, never busy, never written
        iss_valid = 1'b1; iss_rd = 5'd0; alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h0BAD_0BAD;
        #1;
        chk("x0_iss_ready", {31'd0, iss_ready}, 32'd1);
        chk("x0_alu_ready", {31'd0, alu_ready}, 32'd1);
        step();
        iss_valid = 1'b0; alu_valid = 1'b0;
        #1;
        chk("x0_regw", {31'd0, regw}, 32'd0);
        chk("x0_busy", busy, 32'd0);

        // rd=7: RAW/WAW stall, then clear and re-issue on one edge
        iss_valid = 1'b1; iss_rd = 5'd7;
        step();
        rs1 = 5'd7;
        #1;
        chk("busy7_set", busy, 32'h0000_0080);
        chk("raw_stall7", {31'd0, rs_stall}, 32'd1);
        chk("waw_stall7", {31'd0, iss_ready}, 32'd0);
        iss_valid = 1'b0;
        lsu_valid = 1'b1; lsu_rd = 5'd7; lsu_data = 32'h0000_7777;
        #1;
        chk("lsu7_ready", {31'd0, lsu_ready}, 32'd1);
        push(5'd7, 32'h0000_7777);
        step();
        lsu_valid = 1'b0; iss_valid = 1'b1; iss_rd = 5'd7;
        #1;
        chk("reissue7_ready", {31'd0, iss_ready}, 32'd1);
`ifdef WB_BYPASS_EN
        chk("bypass7_stall", {31'd0, rs_stall}, 32'd0);
`else
        chk("nobypass7_stall", {31'd0, rs_stall}, 32'd1);
`endif
        step();
        iss_valid = 1'b0;
        #1;
        chk("set_wins7", busy, 32'h0000_0080);
        chk("raw_stall7_again", {31'd0, rs_stall}, 32'd1);
        rs1 = '0;

        // Mid-operation reset clears the scoreboard
        iss_valid = 1'b1; iss_rd = 5'd9;
        step();
        iss_valid = 1'b0;
        #1;
        chk("busy9_set", busy, 32'h0000_0280);
        nreset = 1'b0;
        step();
        chk("midrst_busy", busy, 32'd0);
        chk("midrst_regw", {31'd0, regw}, 32'd0);
        nreset = 1'b1;
        step();
        step();
        chk("queue_drained", exp_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

endmodule
